// File: rtl/if_fetch_unit_pkg.sv
// Shared state encodings, data width, default NOP word and the {pc,inst} entry type
// used by the instruction-fetch unit and its skid buffer.
package if_fetch_unit_pkg;
  localparam int DATA_SIZE = 32;

  localparam logic [1:0] FETCH_BOOT  = 2'b00;
  localparam logic [1:0] FETCH_RUN   = 2'b01;
  localparam logic [1:0] FETCH_FLUSH = 2'b10;

  localparam logic [DATA_SIZE-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [DATA_SIZE-1:0] pc;
    logic [DATA_SIZE-1:0] inst;
  } fetch_entry_t;

  function automatic logic [DATA_SIZE-1:0] align_pc(input logic [DATA_SIZE-1:0] a);
    return a & {{(DATA_SIZE-2){1'b1}}, 2'b00};
  endfunction
endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// 2-entry {pc,inst} FIFO with a registered head; flush wins over push/pop.
// Head visible the cycle after push; the producer must not push into a full buffer.
module if_fetch_unit_skid_buf
  import if_fetch_unit_pkg::*;
#(
  parameter logic [DATA_SIZE-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_SIZE-1:0] NOP_INST     = NOP_INST_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_dat,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_vld,
  output logic [1:0]   o_count
);
  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic [1:0]   r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 2'd0;
      r_head  <= '{pc: RESET_VECTOR, inst: NOP_INST};
      r_tail  <= '0;
    end else if (i_flush) begin
      r_count     <= 2'd0;
      r_head.inst <= NOP_INST;
    end else if (i_pop && r_count == 2'd2) begin
      r_head <= r_tail;
      if (i_push) r_tail  <= i_push_dat;
      else        r_count <= 2'd1;
    end else if (i_pop) begin
      if (i_push) begin
        r_head <= i_push_dat;
      end else begin
        // Empty: inst falls back to NOP while pc keeps the last value.
        r_head.inst <= NOP_INST;
        r_count     <= 2'd0;
      end
    end else if (i_push) begin
      if (r_count == 2'd0) begin
        r_head  <= i_push_dat;
        r_count <= 2'd1;
      end else begin
        r_tail  <= i_push_dat;
        r_count <= 2'd2;
      end
    end
  end

  assign o_head  = r_head;
  assign o_vld   = (r_count != 2'd0);
  assign o_count = r_count;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, ROM issue, 2-entry skid buffer; first instValid 2 cycles after release,
// 1 instr/cycle with locker=1, stalls without loss when locker=0. FETCH_PERF_EN adds counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [DATA_SIZE-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_SIZE-1:0] PC_STEP      = 32'd4,
  parameter logic [DATA_SIZE-1:0] NOP_INST     = NOP_INST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetIn,
  input  logic                 locker,
  input  logic                 branchTaken,
  input  logic [DATA_SIZE-1:0] branchTarget,
  output logic                 romEn,
  output logic [DATA_SIZE-1:0] romAddr,
  input  logic [DATA_SIZE-1:0] romData,
  output logic [DATA_SIZE-1:0] instOut,
  output logic [DATA_SIZE-1:0] pcOut,
  output logic                 instValid
`ifdef FETCH_PERF_EN
  ,
  output logic [DATA_SIZE-1:0] fetchCount,
  output logic [DATA_SIZE-1:0] stallCount
`endif
);
  logic [1:0]           r_state;
  logic [DATA_SIZE-1:0] r_pc;
  logic [DATA_SIZE-1:0] r_rom_addr;
  logic                 r_inflight;
  logic [DATA_SIZE-1:0] r_inflight_pc;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue;
  logic [2:0]           w_occ;
  logic [1:0]           w_state_nxt;
  logic [1:0]           w_count;
  logic                 w_head_vld;
  fetch_entry_t         w_head;
  fetch_entry_t         w_push_dat;

  always_comb begin
    w_pop       = w_head_vld & locker;
    // Occupancy after this edge; a new issue lands one cycle later, so it must stay below 2.
    w_occ       = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_inflight};
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      FETCH_BOOT: w_issue = 1'b1;
      FETCH_RUN: begin
        w_issue = (w_occ < 3'd2);
        w_push  = r_inflight;
      end
      default: w_issue = 1'b0;
    endcase
    w_state_nxt = FETCH_RUN;
    if (branchTaken && (w_issue || r_state == FETCH_FLUSH)) w_state_nxt = FETCH_FLUSH;
  end

  assign w_push_dat = '{pc: r_inflight_pc, inst: romData};
  assign romEn      = w_issue & resetIn;
  assign romAddr    = w_issue ? r_pc : r_rom_addr;

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      r_state       <= FETCH_BOOT;
      r_pc          <= RESET_VECTOR;
      r_rom_addr    <= RESET_VECTOR;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_VECTOR;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rom_addr    <= r_pc;
        r_inflight_pc <= r_pc;
      end
      if (branchTaken)  r_pc <= align_pc(branchTarget);
      else if (w_issue) r_pc <= r_pc + PC_STEP;
    end
  end

  if_fetch_unit_skid_buf #(
    .RESET_VECTOR(RESET_VECTOR),
    .NOP_INST    (NOP_INST)
  ) u_skid (
    .i_clk     (clk),
    .i_rst_n   (resetIn),
    .i_push    (w_push),
    .i_push_dat(w_push_dat),
    .i_pop     (w_pop),
    .i_flush   (branchTaken),
    .o_head    (w_head),
    .o_vld     (w_head_vld),
    .o_count   (w_count)
  );

  assign instOut   = w_head.inst;
  assign pcOut     = w_head.pc;
  assign instValid = w_head_vld;

`ifdef FETCH_PERF_EN
  logic [DATA_SIZE-1:0] r_fetch_cnt;
  logic [DATA_SIZE-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop)                  r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_head_vld && !locker)  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetchCount = r_fetch_cnt;
  assign stallCount = r_stall_cnt;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: synchronous ROM model plus an in-order PC scoreboard on accepts.
module tb_if_fetch_unit;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetIn = 1'b0;
  logic        locker = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        romEn;
  logic [31:0] romAddr;
  logic [31:0] romData = '0;
  logic [31:0] instOut;
  logic [31:0] pcOut;
  logic        instValid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;
`endif

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;

  if_fetch_unit #(
    .RESET_VECTOR(RV),
    .PC_STEP     (32'd4),
    .NOP_INST    (NOP)
  ) dut (
    .clk         (clk),
    .resetIn     (resetIn),
    .locker      (locker),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .romEn       (romEn),
    .romAddr     (romAddr),
    .romData     (romData),
    .instOut     (instOut),
    .pcOut       (pcOut),
    .instValid   (instValid)
`ifdef FETCH_PERF_EN
    ,
    .fetchCount  (fetchCount),
    .stallCount  (stallCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Synchronous ROM: word appears the cycle after romEn, garbage otherwise.
  always @(posedge clk) romData <= romEn ? rom_word(romAddr) : 32'hDEAD_BEEF;

  // Scoreboard: every accepted (non wrong-path) instruction must match the next expected PC.
  always @(negedge clk) begin
    if (resetIn && instValid && locker && !branchTaken && sb_q.size() != 0) begin
      exp_pc = sb_q.pop_front();
      tests_run++;
      if (pcOut !== exp_pc || instOut !== rom_word(exp_pc)) begin
        tests_failed++;
        $display("FAIL sb_accept: pcOut=%h instOut=%h, expected pc=%h inst=%h",
                 pcOut, instOut, exp_pc, rom_word(exp_pc));
      end
    end
  end

  task automatic do_reset();
    resetIn      = 1'b0;
    locker       = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Release lands mid-period: that period is cycle 0.
  task automatic release_rst();
    next_cycle();
    resetIn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if ({romEn, romAddr, instValid, instOut, pcOut} !== {1'b0, RV, 1'b0, NOP, RV}) begin
      tests_failed++;
      $display("FAIL reset_state: romEn=%b romAddr=%h vld=%b inst=%h pc=%h", romEn, romAddr, instValid, instOut, pcOut);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 12; i++) sb_q.push_back(32'(i * 4));
    locker = 1'b1;
    release_rst();
    @(negedge clk);
    tests_run++;
    if ({romEn, romAddr} !== {1'b1, RV}) begin
      tests_failed++;
      $display("FAIL boot_issue: romEn=%b romAddr=%h, expected 1 %h", romEn, romAddr, RV);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({instValid, romEn, romAddr} !== {1'b0, 1'b1, 32'h4}) begin
      tests_failed++;
      $display("FAIL cycle1: vld=%b romEn=%b romAddr=%h, expected 0 1 00000004", instValid, romEn, romAddr);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({instValid, pcOut} !== {1'b1, RV}) begin
      tests_failed++;
      $display("FAIL first_valid: vld=%b pcOut=%h, expected 1 %h", instValid, pcOut, RV);
    end
    for (int k = 3; k < 16; k++) begin
      next_cycle();
      @(negedge clk);
      tests_run++;
      if ({romEn, romAddr} !== {1'b1, 32'(k * 4)}) begin
        tests_failed++;
        $display("FAIL stream_addr: cycle %0d romEn=%b romAddr=%h, expected 1 %h", k, romEn, romAddr, 32'(k * 4));
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stream_drain: %0d expected PCs never accepted, expected 0", sb_q.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 20; i++) sb_q.push_back(32'(i * 4));
    locker = 1'b1;
    release_rst();
    for (int k = 1; k <= 28; k++) begin
      next_cycle();
      locker = !(k >= 6 && k <= 10);
      @(negedge clk);
      if (k >= 6 && k <= 10) begin
        tests_run++;
        if ({instValid, pcOut, instOut, romEn, romAddr} !== {1'b1, 32'h10, rom_word(32'h10), 1'b0, 32'h14}) begin
          tests_failed++;
          $display("FAIL stall_frozen: cycle %0d vld=%b pc=%h inst=%h romEn=%b romAddr=%h, expected 1 00000010 %h 0 00000014",
                   k, instValid, pcOut, instOut, romEn, romAddr, rom_word(32'h10));
        end
      end
      if (k == 11) begin
        tests_run++;
        if ({romEn, romAddr} !== {1'b1, 32'h18}) begin
          tests_failed++;
          $display("FAIL stall_resume_addr: romEn=%b romAddr=%h, expected 1 00000018", romEn, romAddr);
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stall_drain: %0d expected PCs never accepted, expected 0", sb_q.size());
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    sb_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108};
    locker = 1'b1;
    branchTarget = 32'h0000_0102;
    release_rst();
    for (int k = 1; k <= 14; k++) begin
      next_cycle();
      branchTaken = (k == 5);
      @(negedge clk);
      if (k == 6) begin
        tests_run++;
        if ({instValid, instOut, pcOut, romEn} !== {1'b0, NOP, 32'hC, 1'b0}) begin
          tests_failed++;
          $display("FAIL branch_flush_cycle: vld=%b inst=%h pc=%h romEn=%b, expected 0 %h 0000000c 0", instValid, instOut, pcOut, romEn, NOP);
        end
      end
      if (k == 7) begin
        tests_run++;
        if ({romEn, romAddr} !== {1'b1, 32'h100}) begin
          tests_failed++;
          $display("FAIL branch_target_issue: romEn=%b romAddr=%h, expected 1 00000100", romEn, romAddr);
        end
      end
      if (k == 9) begin
        tests_run++;
        if ({instValid, pcOut} !== {1'b1, 32'h100}) begin
          tests_failed++;
          $display("FAIL branch_target_valid: vld=%b pc=%h, expected 1 00000100", instValid, pcOut);
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL branch_drain: %0d expected PCs never accepted, expected 0", sb_q.size());
    end
  endtask

  task automatic test_branch_idle();
    do_reset();
    sb_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200, 32'h204};
    locker = 1'b1;
    branchTarget = 32'h0000_0200;
    release_rst();
    for (int k = 1; k <= 14; k++) begin
      next_cycle();
      locker      = !(k >= 6 && k <= 8);
      branchTaken = (k == 8);
      @(negedge clk);
      if (k == 9) begin
        tests_run++;
        if ({instValid, romEn, romAddr} !== {1'b0, 1'b1, 32'h200}) begin
          tests_failed++;
          $display("FAIL idle_branch_issue: vld=%b romEn=%b romAddr=%h, expected 0 1 00000200", instValid, romEn, romAddr);
        end
      end
      if (k == 11) begin
        tests_run++;
        if ({instValid, pcOut} !== {1'b1, 32'h200}) begin
          tests_failed++;
          $display("FAIL idle_branch_valid: vld=%b pc=%h, expected 1 00000200", instValid, pcOut);
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL idle_drain: %0d expected PCs never accepted, expected 0", sb_q.size());
    end
  endtask

  task automatic test_wrap_reflush();
    do_reset();
    sb_q = '{32'h0, 32'h4, 32'h8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    locker = 1'b1;
    release_rst();
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      branchTaken  = (k == 5) || (k == 6);
      branchTarget = (k == 5) ? 32'h0000_0500 : 32'hFFFF_FFFA;
      @(negedge clk);
      if (k == 7) begin
        tests_run++;
        if (romEn !== 1'b0) begin
          tests_failed++;
          $display("FAIL reflush_hold: romEn=%b, expected 0", romEn);
        end
      end
      if (k == 8) begin
        tests_run++;
        if ({romEn, romAddr} !== {1'b1, 32'hFFFF_FFF8}) begin
          tests_failed++;
          $display("FAIL reflush_target: romEn=%b romAddr=%h, expected 1 fffffff8", romEn, romAddr);
        end
      end
      if (k == 10) begin
        tests_run++;
        if ({romEn, romAddr} !== {1'b1, 32'h0}) begin
          tests_failed++;
          $display("FAIL pc_wrap_addr: romEn=%b romAddr=%h, expected 1 00000000", romEn, romAddr);
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL wrap_drain: %0d expected PCs never accepted, expected 0", sb_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    sb_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    locker = 1'b1;
    release_rst();
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      locker = (k < 6);
    end
    #2;
    resetIn = 1'b0;
    #1;
    tests_run++;
    if ({instValid, instOut, romEn, pcOut} !== {1'b0, NOP, 1'b0, RV}) begin
      tests_failed++;
      $display("FAIL async_reset: vld=%b inst=%h romEn=%b pc=%h, expected 0 %h 0 %h", instValid, instOut, romEn, pcOut, NOP, RV);
    end
    sb_q = '{32'h0, 32'h4, 32'h8};
    locker = 1'b1;
    release_rst();
    @(negedge clk);
    tests_run++;
    if ({romEn, romAddr} !== {1'b1, RV}) begin
      tests_failed++;
      $display("FAIL restart_issue: romEn=%b romAddr=%h, expected 1 %h", romEn, romAddr, RV);
    end
    repeat (7) next_cycle();
    @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL restart_drain: %0d expected PCs never accepted, expected 0", sb_q.size());
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    @(negedge clk);
    tests_run++;
    if ({fetchCount, stallCount} !== 64'h0) begin
      tests_failed++;
      $display("FAIL perf_reset: fetchCount=%0d stallCount=%0d, expected 0 0", fetchCount, stallCount);
    end
    locker = 1'b1;
    release_rst();
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      locker = (k < 12);
    end
    @(negedge clk);
    tests_run++;
    if ({fetchCount, stallCount} !== {32'd10, 32'd3}) begin
      tests_failed++;
      $display("FAIL perf_counts: fetchCount=%0d stallCount=%0d, expected 10 3", fetchCount, stallCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_flush();
    test_branch_idle();
    test_wrap_reflush();
    test_async_reset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
